// File: rtl/alu_mult_seq.sv
// alu_mult_seq: unsigned WIDTH x WIDTH shift-and-add multiplier that borrows
// the shared CLA ALU for one add per multiplier bit. It requests the ALU with
// alu_req, drives the ALU operands only while it owns the bus, and presents a
// 2*WIDTH product with a start/busy/done handshake towards the control unit.
module alu_mult_seq #(
  parameter int         WIDTH  = 16,
  parameter logic [2:0] ADD_OP = 3'b010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               zero,
  output logic               alu_req,
  input  logic               alu_gnt,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_r,
  input  logic               alu_c_out
);

  // One extra counter bit so the iteration count never aliases WIDTH.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // hi:lo is the running product; lo initially holds the multiplier, whose
  // bits are consumed from the bottom as product bits shift in from hi.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mc;
  logic [CNT_W-1:0] cnt;
  logic             zero_q;

  // Shifted result of the current add: ALU carry becomes the new hi MSB.
  logic [WIDTH-1:0] hi_shift;
  logic [WIDTH-1:0] lo_shift;

  logic             accept;
  logic             step;
  logic             last;

  // A start is honoured in IDLE or DONE; while RUN it is simply dropped.
  assign accept = start && (state != RUN);
  assign step   = (state == RUN) && alu_gnt;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  assign hi_shift = {alu_c_out, alu_r[WIDTH-1:1]};
  assign lo_shift = {alu_r[0], lo[WIDTH-1:1]};

  assign product = {hi, lo};
  assign zero    = zero_q;

  // FSM state register; reset abandons any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and bus/handshake outputs decoded from the state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_req   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = 3'b000;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        alu_op  = ADD_OP;
        alu_a   = hi;
        alu_b   = lo[0] ? mc : '0;
        if (step && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (accept) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch on accept, one shift-and-add per granted RUN cycle,
  // zero flag captured on the final add and cleared on the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      mc     <= '0;
      cnt    <= '0;
      zero_q <= 1'b0;
    end else if (accept) begin
      hi     <= '0;
      lo     <= mplier;
      mc     <= mcand;
      cnt    <= '0;
      zero_q <= 1'b0;
    end else if (step) begin
      hi  <= hi_shift;
      lo  <= lo_shift;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        zero_q <= ({hi_shift, lo_shift} == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Testbench for alu_mult_seq: directed multiplies against a behavioural
// product model, with a per-cycle compare process and literal expectations.
module tb_alu_mult_seq;

  localparam int         W      = 16;
  localparam logic [2:0] ADD_OP = 3'b010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;
  logic          zero;
  logic          alu_req;
  logic          alu_gnt;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_r;
  logic          alu_c_out;

  int n_chk  = 0;
  int n_fail = 0;

  alu_mult_seq #(.WIDTH(W), .ADD_OP(ADD_OP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .zero(zero),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_r(alu_r), .alu_c_out(alu_c_out)
  );

  // Shared single-cycle ALU: plain 17-bit add.
  assign {alu_c_out, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Running product value after k granted adds: the low k multiplier bits
  // have been multiplied in and the remaining multiplier bits sit below.
  function automatic logic [31:0] partial(input logic [31:0] mc, input logic [31:0] mp, input int k);
    logic [63:0] t;
    t = 64'(mc) * 64'(mp & ((32'd1 << k) - 32'd1));
    t = (t << (W - k)) + 64'(mp >> k);
    return t[31:0];
  endfunction

  // Behavioural model: counts granted adds, product from plain arithmetic.
  logic        m_run  = 1'b0;
  logic        m_done = 1'b0;
  int          m_k    = 0;
  logic [31:0] m_mc   = '0;
  logic [31:0] m_mp   = '0;
  logic [31:0] m_prod = '0;
  logic        m_zero = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_k    <= 0;
      m_prod <= '0;
      m_zero <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_run) begin
        if (alu_gnt) begin
          m_k <= m_k + 1;
          if (m_k == W - 1) begin
            m_run  <= 1'b0;
            m_done <= 1'b1;
            m_prod <= m_mc * m_mp;
            m_zero <= ((m_mc * m_mp) == 32'd0);
          end
        end
      end else if (start) begin
        m_run  <= 1'b1;
        m_k    <= 0;
        m_mc   <= 32'(mcand);
        m_mp   <= 32'(mplier);
        m_zero <= 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_prod();
    return m_run ? partial(m_mc, m_mp, m_k) : m_prod;
  endfunction

  logic         prev_run = 1'b0;
  logic         prev_gnt = 1'b1;
  logic [W-1:0] prev_a   = '0;
  logic [W-1:0] prev_b   = '0;
  logic [2:0]   prev_op  = '0;

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_run));
    chk("done", 64'(done), 64'(m_done));
    chk("alu_req", 64'(alu_req), 64'(m_run));
    chk("product", 64'(product), 64'(exp_prod()));
    chk("zero", 64'(zero), 64'(m_zero));
    chk("alu_op", 64'(alu_op), m_run ? 64'(ADD_OP) : 64'd0);
    chk("alu_a", 64'(alu_a), m_run ? 64'(exp_prod() >> W) : 64'd0);
    chk("alu_b", 64'(alu_b), (m_run && m_mp[m_k]) ? 64'(m_mc[W-1:0]) : 64'd0);
    if (prev_run && m_run && !prev_gnt) begin
      chk("stall_a", 64'(alu_a), 64'(prev_a));
      chk("stall_b", 64'(alu_b), 64'(prev_b));
      chk("stall_op", 64'(alu_op), 64'(prev_op));
    end
    prev_run <= m_run;
    prev_gnt <= alu_gnt;
    prev_a   <= alu_a;
    prev_b   <= alu_b;
    prev_op  <= alu_op;
  end

  // Wait for done at posedge+1 phase; n counts cycles waited.
  task automatic wait_done(input bit tog, output int n);
    n = 0;
    while (!done && n < 200) begin
      if (tog) alu_gnt = ~alu_gnt;
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
    alu_gnt = 1'b1;
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit tog, output int n);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tog, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0; alu_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_alu_req", 64'(alu_req), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3 x 5, grant tied high
    chk("pre_alu_req", 64'(alu_req), 64'd0);
    run_mul(16'd3, 16'd5, 1'b0, n);
    chk("lat_3x5", 64'(n), 64'd16);
    chk("prod_3x5", 64'(product), 64'd15);
    chk("zero_3x5", 64'(zero), 64'd0);
    @(posedge clk); #1;
    chk("post_alu_req", 64'(alu_req), 64'd0);
    chk("post_done", 64'(done), 64'd0);

    // all-ones operands: carry out into hi MSB every add
    run_mul(16'hFFFF, 16'hFFFF, 1'b0, n);
    chk("prod_ffff", 64'(product), 64'hFFFE0001);
    @(posedge clk); #1;

    // zero products
    run_mul(16'h1234, 16'h0000, 1'b0, n);
    chk("prod_x0", 64'(product), 64'd0);
    chk("zero_x0", 64'(zero), 64'd1);
    @(posedge clk); #1;
    chk("zero_held", 64'(zero), 64'd1);
    run_mul(16'h0000, 16'h0007, 1'b0, n);
    chk("prod_0x", 64'(product), 64'd0);
    chk("zero_0x", 64'(zero), 64'd1);
    @(posedge clk); #1;

    // 200 x 300 with grant toggling 1,0,1,0
    run_mul(16'd200, 16'd300, 1'b1, n);
    chk("lat_toggle", 64'(n), 64'd32);
    chk("prod_200x300", 64'(product), 64'd60000);
    @(posedge clk); #1;

    // start during RUN is ignored; start in DONE is accepted
    start = 1'b1; mcand = 16'd7; mplier = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; mcand = 16'd100; mplier = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, n);
    chk("lat_ignored", 64'(n), 64'd11);
    chk("prod_ignored", 64'(product), 64'd63);
    start = 1'b1; mcand = 16'd11; mplier = 16'd13;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(1'b0, n);
    chk("lat_b2b", 64'(n), 64'd16);
    chk("prod_b2b", 64'(product), 64'd143);
    @(posedge clk); #1;

    // reset mid-RUN
    start = 1'b1; mcand = 16'd1234; mplier = 16'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("mid_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_alu_req", 64'(alu_req), 64'd0);
    chk("arst_alu_a", 64'(alu_a), 64'd0);
    chk("arst_alu_op", 64'(alu_op), 64'd0);
    chk("arst_product", 64'(product), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_mul(16'd2, 16'd2, 1'b0, n);
    chk("lat_2x2", 64'(n), 64'd16);
    chk("prod_2x2", 64'(product), 64'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
